// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the bus master and the bus target.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  // Value of the R/W bit (first wire bit of the address byte).
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_e;

  // Address byte on the wire is LSB first: bit 0 is R/W and bits 7:1 carry the
  // 7-bit address with address bit 0 in byte bit 1.
  function automatic logic addr_hit(input logic [I2C_BYTE_W-1:0] addr_byte,
                                    input logic [I2C_ADDR_W-1:0] addr);
    return addr_byte[I2C_BYTE_W-1:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, followed by a
// registered level and one-cycle rise/fall pulses aligned with that level.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer chain, last-sample register and edge pulses.
  // When rise/fall is high, level holds the newer of the two compared samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C target: oversamples SCL/SDA, detects START/STOP, matches a 7-bit
// address, ACKs writes and serves read bytes. Bytes are LSB first on the wire.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the address byte (R/W first)
// ADDR_ACK  | driving ACK for a matched address
// WRITE     | shifting in a data byte from the master
// WRITE_ACK | driving ACK for a received data byte
// READ      | driving a data byte to the master
// READ_ACK  | sampling the master's ACK/NACK
// WAIT_STOP | not addressed or NACKed, ignoring bus until START/STOP
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h53,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_rw,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_load,
  output logic                  addr_match,
  output logic                  stop_seen,
  output logic                  busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (scl_in),
    .level (scl_level),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (sda_in),
    .level (sda_level),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_e                  state_q, state_nxt;
  logic [3:0]                  bit_cnt_q, bit_cnt_nxt;
  logic [I2C_BYTE_W-2:0]       shift_q, shift_nxt;
  logic [I2C_BYTE_W-1:0]       tx_byte_q, tx_byte_nxt;
  logic [I2C_BYTE_W-1:0]       rx_data_q, rx_data_nxt;
  logic                        rx_rw_q, rx_rw_nxt;
  logic                        addr_match_q, addr_match_nxt;
  logic                        busy_q, busy_nxt;
  logic                        sda_oe_q, sda_oe_nxt;
  logic                        ack_phase_q, ack_phase_nxt;
  logic                        rx_valid_q, rx_valid_nxt;
  logic                        tx_load_q, tx_load_nxt;
  logic                        stop_seen_q, stop_seen_nxt;

  logic                        scl_high_both;
  logic                        start_det;
  logic                        stop_det;
  logic [I2C_BYTE_W-1:0]       byte_in;

  // SCL is high in both compared samples only if it is high now and did not
  // just rise; an SDA edge coincident with any SCL edge is therefore data.
  assign scl_high_both = scl_level & ~scl_rise;
  assign start_det     = sda_fall & scl_high_both;
  assign stop_det      = sda_rise & scl_high_both;

  // Byte as it will look once the bit on SDA right now is shifted in.
  assign byte_in = {sda_level, shift_q};

  // State and datapath registers; async reset also releases SDA immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_byte_q    <= '0;
      rx_data_q    <= '0;
      rx_rw_q      <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      ack_phase_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_load_q    <= 1'b0;
      stop_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      bit_cnt_q    <= bit_cnt_nxt;
      shift_q      <= shift_nxt;
      tx_byte_q    <= tx_byte_nxt;
      rx_data_q    <= rx_data_nxt;
      rx_rw_q      <= rx_rw_nxt;
      addr_match_q <= addr_match_nxt;
      busy_q       <= busy_nxt;
      sda_oe_q     <= sda_oe_nxt;
      ack_phase_q  <= ack_phase_nxt;
      rx_valid_q   <= rx_valid_nxt;
      tx_load_q    <= tx_load_nxt;
      stop_seen_q  <= stop_seen_nxt;
    end
  end

  // Next-state and output logic; STOP and START override every state.
  always_comb begin
    state_nxt      = state_q;
    bit_cnt_nxt    = bit_cnt_q;
    shift_nxt      = shift_q;
    tx_byte_nxt    = tx_byte_q;
    rx_data_nxt    = rx_data_q;
    rx_rw_nxt      = rx_rw_q;
    addr_match_nxt = addr_match_q;
    busy_nxt       = busy_q;
    sda_oe_nxt     = sda_oe_q;
    ack_phase_nxt  = ack_phase_q;
    rx_valid_nxt   = 1'b0;
    tx_load_nxt    = 1'b0;
    stop_seen_nxt  = 1'b0;

    if (stop_det) begin
      state_nxt      = IDLE;
      stop_seen_nxt  = 1'b1;
      busy_nxt       = 1'b0;
      addr_match_nxt = 1'b0;
      sda_oe_nxt     = 1'b0;
      ack_phase_nxt  = 1'b0;
      bit_cnt_nxt    = '0;
    end else if (start_det) begin
      state_nxt      = ADDR;
      bit_cnt_nxt    = '0;
      sda_oe_nxt     = 1'b0;
      addr_match_nxt = 1'b0;
      busy_nxt       = 1'b1;
      ack_phase_nxt  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_nxt = byte_in[I2C_BYTE_W-1:1];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_nxt = '0;
              if (addr_hit(byte_in, SLAVE_ADDR)) begin
                state_nxt     = ADDR_ACK;
                rx_rw_nxt     = byte_in[0];
                ack_phase_nxt = 1'b0;
              end else begin
                state_nxt = WAIT_STOP;
              end
            end else begin
              bit_cnt_nxt = bit_cnt_q + 4'd1;
            end
          end
        end

        // First fall after the byte drives ACK; the second fall ends the ACK
        // clock and either hands the bus back or starts the read byte.
        ADDR_ACK, WRITE_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_nxt     = 1'b1;
              addr_match_nxt = 1'b1;
              ack_phase_nxt  = 1'b1;
            end else begin
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = '0;
              sda_oe_nxt    = 1'b0;
              if (state_q == ADDR_ACK && rx_rw_q == RW_READ) begin
                tx_load_nxt = 1'b1;
                tx_byte_nxt = tx_data;
                sda_oe_nxt  = ~tx_data[0];
                bit_cnt_nxt = 4'd1;
                state_nxt   = READ;
              end else begin
                state_nxt = WRITE;
              end
            end
          end
        end

        WRITE: begin
          if (scl_rise) begin
            shift_nxt = byte_in[I2C_BYTE_W-1:1];
            if (bit_cnt_q == 4'd7) begin
              rx_data_nxt   = byte_in;
              rx_valid_nxt  = 1'b1;
              bit_cnt_nxt   = '0;
              ack_phase_nxt = 1'b0;
              state_nxt     = WRITE_ACK;
            end else begin
              bit_cnt_nxt = bit_cnt_q + 4'd1;
            end
          end
        end

        // bit_cnt counts bits already placed on the wire.
        READ: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_nxt    = 1'b0;
              bit_cnt_nxt   = '0;
              ack_phase_nxt = 1'b0;
              state_nxt     = READ_ACK;
            end else begin
              sda_oe_nxt  = ~tx_byte_q[bit_cnt_q[2:0]];
              bit_cnt_nxt = bit_cnt_q + 4'd1;
            end
          end
        end

        READ_ACK: begin
          if (!ack_phase_q) begin
            if (scl_rise) begin
              if (!sda_level) begin
                ack_phase_nxt = 1'b1;
              end else begin
                state_nxt = WAIT_STOP;
              end
            end
          end else if (scl_fall) begin
            ack_phase_nxt = 1'b0;
            tx_load_nxt   = 1'b1;
            tx_byte_nxt   = tx_data;
            sda_oe_nxt    = ~tx_data[0];
            bit_cnt_nxt   = 4'd1;
            state_nxt     = READ;
          end
        end

        WAIT_STOP: begin
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_rw      = rx_rw_q;
  assign tx_load    = tx_load_q;
  assign addr_match = addr_match_q;
  assign stop_seen  = stop_seen_q;
  assign busy       = busy_q;

endmodule
